// File: rtl/pixie_vram_arbiter_pkg.sv
// Shared definitions for the Pixie display-RAM arbiter: RAM geometry and the
// write-queue entry layout.
package pixie_vram_arbiter_pkg;

  localparam int PIXIE_ADDR_W = 10;
  localparam int PIXIE_DATA_W = 8;

  typedef struct packed {
    logic [PIXIE_ADDR_W-1:0] addr;
    logic [PIXIE_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/pixie_vram_arbiter_wr_fifo.sv
// DMA write queue: circular buffer of {addr,data} with a separate occupancy count
// and a parallel address lookup that returns the newest matching byte.
module pixie_wr_fifo
  import pixie_vram_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  fifo_entry_t                push_entry_i,
  input  logic                       pop_i,
  output fifo_entry_t                head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  input  logic [PIXIE_ADDR_W-1:0]    lookup_addr_i,
  output logic                       hit_o,
  output logic [PIXIE_DATA_W-1:0]    hit_data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fifo_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en, pop_en;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Fullness uses the registered count, so a same-cycle pop never makes room.
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_en);
    count_d  = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_en) mem_q[wr_ptr_q] <= push_entry_i;
  end

  // Walk oldest to newest so later matches overwrite; the incoming push is newest.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && (mem_q[rd_ptr_q + PTR_W'(i)].addr == lookup_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = mem_q[rd_ptr_q + PTR_W'(i)].data;
      end
    end
    if (push_en && (push_entry_i.addr == lookup_addr_i)) begin
      hit_o      = 1'b1;
      hit_data_o = push_entry_i.data;
    end
  end

endmodule

// File: rtl/pixie_vram_arbiter.sv
// Arbitrates the single-port display RAM: scan-out reads always win, queued DMA
// writes drain into idle cycles, and reads see pending writes via forwarding.
module pixie_vram_arbiter
  import pixie_vram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = PIXIE_ADDR_W,
  parameter int DATA_W     = PIXIE_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_req,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_full,
  input  logic                          rd_req,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          overflow,
  input  logic                          clear_overflow,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  output logic                          ram_we,
  input  logic [DATA_W-1:0]             ram_rdata
);

  fifo_entry_t       push_entry, head;
  logic              fifo_empty, fifo_pop;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  logic              rd_valid_q, fwd_hit_q, overflow_q, overflow_d;
  logic [DATA_W-1:0] fwd_data_q;

  assign push_entry = '{addr: wr_addr, data: wr_data};
  assign fifo_pop   = !rd_req && !fifo_empty;

  pixie_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (wr_req),
    .push_entry_i (push_entry),
    .pop_i        (fifo_pop),
    .head_o       (head),
    .count_o      (pending),
    .full_o       (wr_full),
    .empty_o      (fifo_empty),
    .lookup_addr_i(rd_addr),
    .hit_o        (fwd_hit),
    .hit_data_o   (fwd_data)
  );

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (rd_req) begin
      ram_addr = rd_addr;
    end else if (fifo_pop) begin
      ram_addr  = head.addr;
      ram_wdata = head.data;
      ram_we    = 1'b1;
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (clear_overflow)     overflow_d = 1'b0;
    if (wr_req && wr_full)  overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      fwd_hit_q  <= rd_req && fwd_hit;
      fwd_data_q <= fwd_data;
      overflow_q <= overflow_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign overflow = overflow_q;
  assign rd_data  = !rd_valid_q ? '0 : (fwd_hit_q ? fwd_data_q : ram_rdata);

endmodule

// File: tb/tb_pixie_vram_arbiter.sv
// Directed bench for pixie_vram_arbiter: a vector table observed once per cycle
// plus hand sequences for overflow priority and mid-operation reset.
module tb_pixie_vram_arbiter;

  logic       clk;
  logic       reset;
  logic       wr_req;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_full;
  logic       rd_req;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] pending;
  logic       overflow;
  logic       clear_overflow;
  logic [9:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [7:0] ram_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  pixie_vram_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_full       (wr_full),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .pending       (pending),
    .overflow      (overflow),
    .clear_overflow(clear_overflow),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_we        (ram_we),
    .ram_rdata     (ram_rdata)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous 1K x 8 RAM model; preloaded once during the first reset.
  logic [7:0] ram_mem [1024];
  logic       ram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int j = 0; j < 1024; j++) ram_mem[j] <= 8'h00;
      ram_mem[10'h100] <= 8'hC3;
      ram_init_done    <= 1'b1;
    end else if (ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= ram_mem[ram_addr];
  end

  // One record per cycle: inputs driven that cycle, outputs expected that cycle.
  typedef struct {
    logic       wr;
    logic [9:0] wa;
    logic [7:0] wd;
    logic       rd;
    logic [9:0] ra;
    logic       clr;
    logic       e_we;
    logic [9:0] e_addr;
    logic [7:0] e_wdata;
    logic       e_full;
    logic [2:0] e_pend;
    logic       e_rv;
    logic [7:0] e_rdata;
    logic       e_ovf;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic vec_t mk(input int w, input int wa, input int wd, input int r,
                              input int ra, input int c, input int we, input int ea,
                              input int ewd, input int f, input int p, input int rv,
                              input int rdt, input int o);
    vec_t v;
    v.wr = 1'(w);   v.wa = 10'(wa);     v.wd = 8'(wd);
    v.rd = 1'(r);   v.ra = 10'(ra);     v.clr = 1'(c);
    v.e_we = 1'(we); v.e_addr = 10'(ea); v.e_wdata = 8'(ewd);
    v.e_full = 1'(f); v.e_pend = 3'(p); v.e_rv = 1'(rv);
    v.e_rdata = 8'(rdt); v.e_ovf = 1'(o);
    return v;
  endfunction

  // Scoreboard compare
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: apply inputs just after the falling edge, then settle.
  task automatic drive(input int w, input int wa, input int wd, input int r,
                       input int ra, input int c, input int rst);
    @(negedge clk);
    wr_req         = 1'(w);
    wr_addr        = 10'(wa);
    wr_data        = 8'(wd);
    rd_req         = 1'(r);
    rd_addr        = 10'(ra);
    clear_overflow = 1'(c);
    reset          = 1'(rst);
    #1;
  endtask

  int we_pulses;

  initial begin
    // Single write drains into the next idle cycle
    vecs[0]  = mk(1,'h005,'hA5, 0,'h000,0,  0,'h000,'h00, 0,0, 0,'h00, 0);
    vecs[1]  = mk(0,'h000,'h00, 0,'h000,0,  1,'h005,'hA5, 0,1, 0,'h00, 0);
    vecs[2]  = mk(0,'h000,'h00, 0,'h000,0,  0,'h000,'h00, 0,0, 0,'h00, 0);
    // Reads starve writes: queue fills, fifth write is dropped, then drains in order
    vecs[3]  = mk(1,'h010,'h50, 1,'h100,0,  0,'h100,'h00, 0,0, 0,'h00, 0);
    vecs[4]  = mk(1,'h011,'h51, 1,'h100,0,  0,'h100,'h00, 0,1, 1,'hC3, 0);
    vecs[5]  = mk(1,'h012,'h52, 1,'h100,0,  0,'h100,'h00, 0,2, 1,'hC3, 0);
    vecs[6]  = mk(1,'h013,'h53, 1,'h100,0,  0,'h100,'h00, 0,3, 1,'hC3, 0);
    vecs[7]  = mk(1,'h014,'h54, 1,'h100,0,  0,'h100,'h00, 1,4, 1,'hC3, 0);
    vecs[8]  = mk(0,'h000,'h00, 1,'h100,0,  0,'h100,'h00, 1,4, 1,'hC3, 1);
    vecs[9]  = mk(0,'h000,'h00, 0,'h000,0,  1,'h010,'h50, 1,4, 1,'hC3, 1);
    vecs[10] = mk(0,'h000,'h00, 0,'h000,0,  1,'h011,'h51, 0,3, 0,'h00, 1);
    vecs[11] = mk(0,'h000,'h00, 0,'h000,0,  1,'h012,'h52, 0,2, 0,'h00, 1);
    vecs[12] = mk(0,'h000,'h00, 0,'h000,0,  1,'h013,'h53, 0,1, 0,'h00, 1);
    vecs[13] = mk(0,'h000,'h00, 0,'h000,0,  0,'h000,'h00, 0,0, 0,'h00, 1);
    // clear_overflow alone
    vecs[14] = mk(0,'h000,'h00, 0,'h000,1,  0,'h000,'h00, 0,0, 0,'h00, 1);
    vecs[15] = mk(0,'h000,'h00, 0,'h000,0,  0,'h000,'h00, 0,0, 0,'h00, 0);
    // Two queued writes to 0x020; read forwards the newest (0x22), RAM still 0
    vecs[16] = mk(1,'h020,'h11, 1,'h3FF,0,  0,'h3FF,'h00, 0,0, 0,'h00, 0);
    vecs[17] = mk(1,'h020,'h22, 1,'h3FF,0,  0,'h3FF,'h00, 0,1, 1,'h00, 0);
    vecs[18] = mk(0,'h000,'h00, 1,'h020,0,  0,'h020,'h00, 0,2, 1,'h00, 0);
    vecs[19] = mk(0,'h000,'h00, 0,'h000,0,  1,'h020,'h11, 0,2, 1,'h22, 0);
    vecs[20] = mk(0,'h000,'h00, 0,'h000,0,  1,'h020,'h22, 0,1, 0,'h00, 0);
    vecs[21] = mk(0,'h000,'h00, 0,'h000,0,  0,'h000,'h00, 0,0, 0,'h00, 0);
    // Same-cycle push and read of 0x030
    vecs[22] = mk(1,'h030,'h7E, 1,'h030,0,  0,'h030,'h00, 0,0, 0,'h00, 0);
    vecs[23] = mk(0,'h000,'h00, 0,'h000,0,  1,'h030,'h7E, 0,1, 1,'h7E, 0);
    // Plain RAM read of the drained 0x020 byte
    vecs[24] = mk(0,'h000,'h00, 1,'h020,0,  0,'h020,'h00, 0,0, 0,'h00, 0);
    vecs[25] = mk(0,'h000,'h00, 0,'h000,0,  0,'h000,'h00, 0,0, 1,'h22, 0);

    reset = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0; clear_overflow = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      drive(int'(vecs[i].wr), int'(vecs[i].wa), int'(vecs[i].wd), int'(vecs[i].rd),
            int'(vecs[i].ra), int'(vecs[i].clr), 0);
      check($sformatf("v%0d_ram_we", i),    int'(ram_we),   int'(vecs[i].e_we));
      check($sformatf("v%0d_ram_addr", i),  int'(ram_addr), int'(vecs[i].e_addr));
      if (vecs[i].e_we)
        check($sformatf("v%0d_ram_wdata", i), int'(ram_wdata), int'(vecs[i].e_wdata));
      check($sformatf("v%0d_wr_full", i),   int'(wr_full),  int'(vecs[i].e_full));
      check($sformatf("v%0d_pending", i),   int'(pending),  int'(vecs[i].e_pend));
      check($sformatf("v%0d_rd_valid", i),  int'(rd_valid), int'(vecs[i].e_rv));
      if (vecs[i].e_rv)
        check($sformatf("v%0d_rd_data", i), int'(rd_data),  int'(vecs[i].e_rdata));
      check($sformatf("v%0d_overflow", i),  int'(overflow), int'(vecs[i].e_ovf));
    end

    // Fill the queue under reads; the fifth write drops while clear is asserted
    for (int k = 0; k < 5; k++)
      drive(1, 'h040 + k, 'h60 + k, 1, 'h200, (k == 4) ? 1 : 0, 0);
    drive(1, 'h045, 'h65, 1, 'h200, 1, 0);
    check("seq_ovf_set_beats_clear", int'(overflow), 1);
    check("seq_full_pending",        int'(pending),  4);
    check("seq_full_flag",           int'(wr_full),  1);

    // Reset with writes queued and a read in flight
    drive(0, 0, 0, 1, 'h200, 0, 1);
    check("seq_ovf_hold_drop_clear", int'(overflow), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("seq_rst_pending",  int'(pending),  0);
    check("seq_rst_rd_valid", int'(rd_valid), 0);
    check("seq_rst_rd_data",  int'(rd_data),  0);
    check("seq_rst_overflow", int'(overflow), 0);
    check("seq_rst_wr_full",  int'(wr_full),  0);
    we_pulses = int'(ram_we);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      we_pulses += int'(ram_we);
    end
    check("seq_no_we_after_reset", we_pulses, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
